fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 167 ++++++++++++++++
 tb/tb_fetch_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer.
// Owns the fetch PC and sequences instruction-memory requests through three states:
//   RUN  - normal fetch, one instruction per cycle when memory is ready
//   MISS - waiting on instruction memory; the request is held until it returns
//   HALT - HLT reached; fetch stops until reset
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   stall      - decode hazard hold; freezes PC and IF/ID
//   br_taken   - resolved branch/jump taken this cycle
//   br_target  - redirect address, qualified by br_taken
//   halt_dec   - HLT decoded in ID
//   imem_rdy   - instruction memory returns data this cycle
//   imem_req   - fetch request
//   imem_addr  - fetch address (always pc)
//   pc         - registered fetch PC
//   pc_plus2   - pc + 2, wrapping
//   if_id_wen  - IF/ID write enable
//   if_valid   - IF/ID data valid (0 writes a bubble)
//   flush      - squash IF/ID
//   halted     - sequencer is in HALT
//   miss_cycles- saturating count of cycles spent in MISS
module fetch_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        halt_dec,
  input  logic        imem_rdy,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        if_id_wen,
  output logic        if_valid,
  output logic        flush,
  output logic        halted,
  output logic [15:0] miss_cycles
);

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StMiss = 2'd1,
    StHalt = 2'd2
  } state_e;

  state_e      r_state, w_state_d;
  logic [15:0] r_pc, w_pc_d;
  logic        r_pend_vld, w_pend_vld_d;
  logic [15:0] r_pend_pc, w_pend_pc_d;
  logic        r_halt_rec, w_halt_rec_d;
  logic [15:0] r_miss_cycles;
  logic [15:0] w_pc_inc;
  logic        w_halt_now;

  assign w_pc_inc    = r_pc + 16'd2;
  assign pc          = r_pc;
  assign pc_plus2    = w_pc_inc;
  assign imem_addr   = r_pc;
  assign miss_cycles = r_miss_cycles;

  // A HLT seen this cycle only counts when it is not squashed by a branch or held by a stall.
  assign w_halt_now = halt_dec & ~br_taken & ~stall;

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_pend_vld_d = r_pend_vld;
    w_pend_pc_d  = r_pend_pc;
    w_halt_rec_d = r_halt_rec;
    imem_req     = 1'b0;
    if_id_wen    = 1'b0;
    if_valid     = 1'b0;
    flush        = 1'b0;
    halted       = 1'b0;

    if (!rst) begin
      unique case (r_state)
        StRun: begin
          imem_req = 1'b1;
          if (br_taken) begin
            w_pc_d    = br_target;
            flush     = 1'b1;
            if_id_wen = 1'b1;
          end else if (stall) begin
            // hold everything
          end else if (halt_dec) begin
            w_state_d = StHalt;
          end else if (imem_rdy) begin
            w_pc_d    = w_pc_inc;
            if_id_wen = 1'b1;
            if_valid  = 1'b1;
          end else begin
            if_id_wen = 1'b1;
            w_state_d = StMiss;
          end
        end

        StMiss: begin
          imem_req = 1'b1;
          // The outstanding request cannot be aborted, so a redirect is parked until it returns.
          if (br_taken) begin
            flush        = 1'b1;
            if_id_wen    = 1'b1;
            w_pend_vld_d = 1'b1;
            w_pend_pc_d  = br_target;
            w_halt_rec_d = 1'b0;
          end else if (w_halt_now) begin
            w_halt_rec_d = 1'b1;
          end

          if (imem_rdy) begin
            w_state_d    = StRun;
            w_pend_vld_d = 1'b0;
            w_halt_rec_d = 1'b0;
            if (br_taken) begin
              w_pc_d = br_target;
            end else if (r_pend_vld) begin
              w_pc_d    = r_pend_pc;
              if_id_wen = ~stall;
            end else if (r_halt_rec || w_halt_now) begin
              w_state_d = StHalt;
            end else if (!stall) begin
              w_pc_d    = w_pc_inc;
              if_id_wen = 1'b1;
              if_valid  = 1'b1;
            end
          end else if (!br_taken) begin
            if_id_wen = ~stall;
          end
        end

        StHalt: begin
          halted = 1'b1;
        end

        default: begin
          w_state_d = StRun;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StRun;
      r_pc          <= RESET_PC;
      r_pend_vld    <= 1'b0;
      r_pend_pc     <= 16'h0000;
      r_halt_rec    <= 1'b0;
      r_miss_cycles <= 16'h0000;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_pend_vld <= w_pend_vld_d;
      r_pend_pc  <= w_pend_pc_d;
      r_halt_rec <= w_halt_rec_d;
      if (r_state == StMiss && r_miss_cycles != 16'hFFFF) begin
        r_miss_cycles <= r_miss_cycles + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: self-checking bench for fetch_seq.
// Each vector holds the inputs for one cycle, the combinational outputs expected before the
// clock edge, and the pc / miss_cycles expected after it. Vectors are queued as they are
// driven and checked by a monitor at the following rising edge.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic        halt_dec = 1'b0;
  logic        imem_rdy = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        if_id_wen;
  logic        if_valid;
  logic        flush;
  logic        halted;
  logic [15:0] miss_cycles;

  fetch_seq #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .halt_dec   (halt_dec),
    .imem_rdy   (imem_rdy),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .pc_plus2   (pc_plus2),
    .if_id_wen  (if_id_wen),
    .if_valid   (if_valid),
    .flush      (flush),
    .halted     (halted),
    .miss_cycles(miss_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, stall, br, halt, rdy;
    logic [15:0] tgt;
    logic        req, wen, vld, fl, hlt;
    logic [15:0] pc;    // before the edge; X = unknown, not checked
    logic [15:0] pcn;   // after the edge
    int          miss;  // after the edge; -1 = not checked
  } vec_t;

  vec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(input string nm, input logic r, input logic s, input logic b,
                             input logic [15:0] t, input logic h, input logic rd,
                             input logic req, input logic wen, input logic vld, input logic fl,
                             input logic hl, input logic [15:0] p, input logic [15:0] pn,
                             input int m);
    vec_t e;
    e.name = nm; e.rst = r; e.stall = s; e.br = b; e.tgt = t; e.halt = h; e.rdy = rd;
    e.req = req; e.wen = wen; e.vld = vld; e.fl = fl; e.hlt = hl;
    e.pc = p; e.pcn = pn; e.miss = m;
    return e;
  endfunction

  task automatic drive(input vec_t e);
    rst = e.rst; stall = e.stall; br_taken = e.br; br_target = e.tgt;
    halt_dec = e.halt; imem_rdy = e.rdy;
  endtask

  task automatic apply(input vec_t e);
    @(negedge clk);
    drive(e);
    q.push_back(e);
  endtask

  // Monitor: combinational outputs just before the edge, registered state just after.
  always @(posedge clk) begin
    if (q.size() > 0) begin
      vec_t e;
      e = q.pop_front();
      chk({e.name, " imem_req"},  16'(imem_req),  16'(e.req));
      chk({e.name, " if_id_wen"}, 16'(if_id_wen), 16'(e.wen));
      chk({e.name, " if_valid"},  16'(if_valid),  16'(e.vld));
      chk({e.name, " flush"},     16'(flush),     16'(e.fl));
      chk({e.name, " halted"},    16'(halted),    16'(e.hlt));
      if (!$isunknown(e.pc)) begin
        chk({e.name, " pc"},        pc,        e.pc);
        chk({e.name, " imem_addr"}, imem_addr, e.pc);
        chk({e.name, " pc_plus2"},  pc_plus2,  e.pc + 16'd2);
      end
      #1;
      chk({e.name, " pc_next"}, pc, e.pcn);
      if (e.miss >= 0) chk({e.name, " miss_cycles"}, miss_cycles, 16'(e.miss));
    end
  end

  localparam logic [15:0] PX = 16'hxxxx;

  initial begin
    vec_t tbl[$];
    vec_t e;

    //                name       rst st br tgt      hl rd  req wen vld fl hlt pc      pcn    miss
    tbl.push_back(v("rst",       1, 0, 0, 16'h0000, 0, 1,  0, 0, 0, 0, 0, PX,      16'h0000, 0));
    tbl.push_back(v("seq0",      0, 0, 0, 16'h0000, 0, 1,  1, 1, 1, 0, 0, 16'h0000, 16'h0002, 0));
    tbl.push_back(v("seq1",      0, 0, 0, 16'h0000, 0, 1,  1, 1, 1, 0, 0, 16'h0002, 16'h0004, 0));
    tbl.push_back(v("seq2",      0, 0, 0, 16'h0000, 0, 1,  1, 1, 1, 0, 0, 16'h0004, 16'h0006, 0));
    tbl.push_back(v("seq3",      0, 0, 0, 16'h0000, 0, 1,  1, 1, 1, 0, 0, 16'h0006, 16'h0008, 0));
    tbl.push_back(v("br10",      0, 0, 1, 16'h0010, 0, 1,  1, 1, 0, 1, 0, 16'h0008, 16'h0010, 0));
    tbl.push_back(v("miss_in",   0, 0, 0, 16'h0000, 0, 0,  1, 1, 0, 0, 0, 16'h0010, 16'h0010, 0));
    tbl.push_back(v("miss1",     0, 0, 0, 16'h0000, 0, 0,  1, 1, 0, 0, 0, 16'h0010, 16'h0010, 1));
    tbl.push_back(v("miss2",     0, 0, 0, 16'h0000, 0, 0,  1, 1, 0, 0, 0, 16'h0010, 16'h0010, 2));
    tbl.push_back(v("refill",    0, 0, 0, 16'h0000, 0, 1,  1, 1, 1, 0, 0, 16'h0010, 16'h0012, 3));
    tbl.push_back(v("run12",     0, 0, 0, 16'h0000, 0, 1,  1, 1, 1, 0, 0, 16'h0012, 16'h0014, 3));
    tbl.push_back(v("br20",      0, 0, 1, 16'h0020, 0, 1,  1, 1, 0, 1, 0, 16'h0014, 16'h0020, 3));
    tbl.push_back(v("miss20",    0, 0, 0, 16'h0000, 0, 0,  1, 1, 0, 0, 0, 16'h0020, 16'h0020, 3));
    tbl.push_back(v("missbr",    0, 0, 1, 16'h0100, 0, 0,  1, 1, 0, 1, 0, 16'h0020, 16'h0020, 4));
    tbl.push_back(v("misswait",  0, 0, 0, 16'h0000, 0, 0,  1, 1, 0, 0, 0, 16'h0020, 16'h0020, 5));
    tbl.push_back(v("discard",   0, 0, 0, 16'h0000, 0, 1,  1, 1, 0, 0, 0, 16'h0020, 16'h0100, 6));
    tbl.push_back(v("run100",    0, 0, 0, 16'h0000, 0, 1,  1, 1, 1, 0, 0, 16'h0100, 16'h0102, 6));
    tbl.push_back(v("miss102",   0, 0, 0, 16'h0000, 0, 0,  1, 1, 0, 0, 0, 16'h0102, 16'h0102, 6));
    tbl.push_back(v("refetch",   0, 1, 0, 16'h0000, 0, 1,  1, 0, 0, 0, 0, 16'h0102, 16'h0102, 7));
    tbl.push_back(v("run102",    0, 0, 0, 16'h0000, 0, 1,  1, 1, 1, 0, 0, 16'h0102, 16'h0104, 7));
    tbl.push_back(v("stall",     0, 1, 0, 16'h0000, 0, 1,  1, 0, 0, 0, 0, 16'h0104, 16'h0104, 7));
    tbl.push_back(v("brprio",    0, 1, 1, 16'h0040, 1, 0,  1, 1, 0, 1, 0, 16'h0104, 16'h0040, 7));
    tbl.push_back(v("run40",     0, 0, 0, 16'h0000, 0, 1,  1, 1, 1, 0, 0, 16'h0040, 16'h0042, 7));
    tbl.push_back(v("miss42",    0, 0, 0, 16'h0000, 0, 0,  1, 1, 0, 0, 0, 16'h0042, 16'h0042, 7));
    tbl.push_back(v("misshlt",   0, 0, 0, 16'h0000, 1, 0,  1, 1, 0, 0, 0, 16'h0042, 16'h0042, 8));
    tbl.push_back(v("hltfill",   0, 0, 0, 16'h0000, 0, 1,  1, 0, 0, 0, 0, 16'h0042, 16'h0042, 9));
    tbl.push_back(v("halt42",    0, 0, 0, 16'h0000, 0, 1,  0, 0, 0, 0, 1, 16'h0042, 16'h0042, 9));
    tbl.push_back(v("rst2",      1, 0, 0, 16'h0000, 0, 1,  0, 0, 0, 0, 0, 16'h0042, 16'h0000, 0));
    tbl.push_back(v("br30",      0, 0, 1, 16'h0030, 0, 1,  1, 1, 0, 1, 0, 16'h0000, 16'h0030, 0));
    tbl.push_back(v("hlt30",     0, 0, 0, 16'h0000, 1, 1,  1, 0, 0, 0, 0, 16'h0030, 16'h0030, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // HALT is sticky for 10 cycles, even against branches and memory activity.
    for (int i = 0; i < 10; i++) begin
      e = v("halt30", 0, i[0], (i == 3), 16'h0100, i[1], 1,
            0, 0, 0, 0, 1, 16'h0030, 16'h0030, 0);
      apply(e);
    end
    apply(v("rst3",     1, 0, 0, 16'h0000, 0, 1,  0, 0, 0, 0, 0, 16'h0030, 16'h0000, 0));
    apply(v("run0",     0, 0, 0, 16'h0000, 0, 1,  1, 1, 1, 0, 0, 16'h0000, 16'h0002, 0));

    // Reset in the middle of a MISS.
    apply(v("miss2b",   0, 0, 0, 16'h0000, 0, 0,  1, 1, 0, 0, 0, 16'h0002, 16'h0002, 0));
    apply(v("miss2c",   0, 0, 0, 16'h0000, 0, 0,  1, 1, 0, 0, 0, 16'h0002, 16'h0002, 1));
    apply(v("rstmiss",  1, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 0, 0, 16'h0002, 16'h0000, 0));
    apply(v("runrst",   0, 0, 0, 16'h0000, 0, 1,  1, 1, 1, 0, 0, 16'h0000, 16'h0002, 0));

    // PC wrap-around.
    apply(v("brfffe",   0, 0, 1, 16'hFFFE, 0, 1,  1, 1, 0, 1, 0, 16'h0002, 16'hFFFE, 0));
    apply(v("wrap",     0, 0, 0, 16'h0000, 0, 1,  1, 1, 1, 0, 0, 16'hFFFE, 16'h0000, 0));

    // miss_cycles saturation: sit in MISS past 2^16 cycles.
    apply(v("misslong", 0, 0, 0, 16'h0000, 0, 0,  1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0));
    repeat (65540) @(negedge clk);
    apply(v("satmiss",  0, 0, 0, 16'h0000, 0, 0,  1, 1, 0, 0, 0, 16'h0000, 16'h0000, 65535));
    apply(v("satfill",  0, 0, 0, 16'h0000, 0, 1,  1, 1, 1, 0, 0, 16'h0000, 16'h0002, 65535));
    apply(v("satrun",   0, 0, 0, 16'h0000, 0, 1,  1, 1, 1, 0, 0, 16'h0002, 16'h0004, 65535));

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending vectors expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
